// File: rtl/wr_512b_to_bram.sv
// ============================================================================
// Module   : wr_512b_to_bram
// Purpose  : Stores one 512-bit row into BRAM as WORDS_PER_ROW consecutive
//            WORD_W-bit words. Each word goes through a four-phase
//            addr/data/trig/done handshake with the BRAM write controller.
//            Upstream uses a level trig/done handshake: i_trig is held until
//            o_done is seen, and o_done is held until i_trig drops.
// Revision : 1.0 - initial release
//
// Ports
//   i_clk              system clock, rising edge
//   i_rst              asynchronous active-high reset
//   i_trig             upstream level request
//   o_done             transfer complete, held while i_trig stays high
//   i_wr_row_num       target row number
//   i_wr_data_512b     row payload, word k = bits [32k+31:32k]
//   o_wr_to_bram_addr  BRAM word address {row, k}
//   o_wr_to_bram_data  word k of the latched row
//   o_wr_to_bram_trig  write request to the BRAM controller
//   i_wr_to_bram_done  write acknowledge from the BRAM controller
//   debug_port         debug observation (see below)
//
// Build option
//   WR_512B_DEBUG_EN : when defined, debug_port = {20'd0, k[3:0], state[7:0]}.
//                      When undefined, debug_port is constant zero.
// ============================================================================
`default_nettype none

module wr_512b_to_bram #(
  parameter int ROW_W         = 9,
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_ROW = 16,
  parameter int ADDR_W        = 13
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_trig,
  output logic                            o_done,
  input  logic [ROW_W-1:0]                i_wr_row_num,
  input  logic [WORD_W*WORDS_PER_ROW-1:0] i_wr_data_512b,
  output logic [ADDR_W-1:0]               o_wr_to_bram_addr,
  output logic [WORD_W-1:0]               o_wr_to_bram_data,
  output logic                            o_wr_to_bram_trig,
  input  logic                            i_wr_to_bram_done,
  output logic [31:0]                     debug_port
);

  localparam int KW     = $clog2(WORDS_PER_ROW);
  localparam int DATA_W = WORD_W * WORDS_PER_ROW;
  localparam logic [KW-1:0] C_LAST_K = KW'(WORDS_PER_ROW - 1);

  typedef enum logic [7:0] {
    IDLE         = 8'd0,
    WAIT_DONE    = 8'd1,
    WAIT_RELEASE = 8'd2,
    FINISH       = 8'd3
  } state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                trig_q, trig_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;

  logic [KW-1:0]       k_next;
  logic [WORD_W-1:0]   next_word;

  // Word that follows the one currently presented, taken from the latched
  // row so that upstream changes during a transfer are invisible.
  assign k_next    = k_q + KW'(1);
  assign next_word = data_q[32'(k_next)*WORD_W +: WORD_W];

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      row_q   <= '0;
      data_q  <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      data_q  <= data_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    row_d   = row_q;
    data_d  = data_q;
    trig_d  = trig_q;
    done_d  = done_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (i_trig) begin
          // Capture the whole request and present word 0 straight away so
          // the BRAM request rises one cycle after i_trig is seen.
          row_d   = i_wr_row_num;
          data_d  = i_wr_data_512b;
          k_d     = '0;
          addr_d  = {i_wr_row_num, {KW{1'b0}}};
          wdata_d = i_wr_data_512b[WORD_W-1:0];
          trig_d  = 1'b1;
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (i_wr_to_bram_done) begin
          trig_d  = 1'b0;
          state_d = WAIT_RELEASE;
        end
      end

      WAIT_RELEASE: begin
        // Only move on once the controller has dropped its acknowledge,
        // completing the four-phase cycle for this word.
        if (!i_wr_to_bram_done) begin
          if (k_q == C_LAST_K) begin
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            k_d     = k_next;
            addr_d  = {row_q, k_next};
            wdata_d = next_word;
            trig_d  = 1'b1;
            state_d = WAIT_DONE;
          end
        end
      end

      FINISH: begin
        // Return to IDLE only; a fresh request is considered next cycle.
        if (!i_trig) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        trig_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign o_done            = done_q;
  assign o_wr_to_bram_trig = trig_q;
  assign o_wr_to_bram_addr = addr_q;
  assign o_wr_to_bram_data = wdata_q;

`ifdef WR_512B_DEBUG_EN
  assign debug_port = {16'd0, 4'd0, 4'(k_q), state_q};
`else
  assign debug_port = 32'd0;
`endif

endmodule

`default_nettype wire
